// File: rtl/apb_master_arb.sv
// APB3/APB4 bus master shared by NUM_REQ internal requesters (CPU, DMA, debug).
// Round-robin grant, one-hot slave decode, SETUP/ACCESS sequencing and a pready timeout.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | bus quiet; grant next requester round-robin and latch its request
//   S_SETUP  | psel asserted, penable low, timeout counter cleared
//   S_ACCESS | penable high; wait for pready or abort on timeout
module apb_master_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_NUM  = 8,
  parameter int NUM_REQ    = 2,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]          req_strb,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          pwrite,
  output logic [SLAVE_NUM-1:0]          psel,
  output logic                          penable,
  output logic [3:0]                    pstrb,
  output logic [2:0]                    pprot,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int SW  = $clog2(SLAVE_NUM);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [3:0]              strb_q, strb_d;
  logic [2:0]              prot_q, prot_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    gnt_found;
  logic [IDW-1:0]          gnt;
  logic [IDW:0]            cand_sum;
  logic [IDW-1:0]          cand;
  logic [IDW:0]            rr_sum;
  logic [SLAVE_NUM-1:0]    psel_dec;

  // Search starts at the rr pointer and wraps, so the pointer alone sets priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      cand = cand_sum[IDW-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt       = cand;
      end
    end
  end

  always_comb begin
    rr_sum = {1'b0, gnt} + (IDW+1)'(1);
    if (rr_sum >= (IDW+1)'(NUM_REQ)) begin
      rr_sum = '0;
    end
  end

  always_comb begin
    psel_dec = '0;
    psel_dec[addr_q[SEL_LSB +: SW]] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    strb_d      = strb_q;
    prot_d      = prot_q;
    tmo_d       = tmo_q;
    req_ready   = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt] = 1'b1;
          id_d           = gnt;
          rr_d           = rr_sum[IDW-1:0];
          for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt == IDW'(k)) begin
              addr_d  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
              write_d = req_write[k];
              strb_d  = req_strb[k*4 +: 4];
              prot_d  = req_prot[k*3 +: 3];
            end
          end
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmo_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d[id_q] = 1'b1;
          rsp_err_d         = pslverr;
          rsp_rdata_d       = write_q ? '0 : prdata;
          state_d           = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Hung slave: release the bus and report an error with no data.
          rsp_valid_d[id_q] = 1'b1;
          rsp_err_d         = 1'b1;
          state_d           = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    paddr   = '0;
    pwdata  = '0;
    pwrite  = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pstrb   = 4'b0000;
    pprot   = 3'b000;
    if (state_q == S_SETUP || state_q == S_ACCESS) begin
      paddr   = addr_q;
      pwdata  = wdata_q;
      pwrite  = write_q;
      psel    = psel_dec;
      penable = (state_q == S_ACCESS);
      pstrb   = write_q ? strb_q : 4'b0000;
      pprot   = prot_q;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      strb_q      <= '0;
      prot_q      <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- APB3/APB4 bus master that shares one APB bus among NUM_REQ internal requesters (CPU core, DMA, debug).
- Round-robin arbitration picks one requester; the block decodes the address to a one-hot psel and sequences the IDLE/SETUP/ACCESS protocol.
- Returns read data and error to the granted requester.
- Enforces a pready timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- SLAVE_NUM, 8, number of slaves; must be a power of 2
- NUM_REQ, 2, number of requesters, 2..4
- SEL_LSB, 12, lowest address bit of the slave-select field; slave index = paddr[SEL_LSB +: log2(SLAVE_NUM)]
- TIMEOUT, 16, maximum ACCESS cycles allowed with pready low

Ports:
- pclk  in  1  APB clock, single clock domain
- preset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transfer request
- req_ready  out  NUM_REQ  one-cycle pulse: request accepted
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester 0 in LSBs
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*4  packed byte strobes
- req_prot  in  NUM_REQ*3  packed protection attributes
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid
- rsp_err  out  1  pslverr or timeout; valid with rsp_valid
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pwrite  out  1  APB direction
- psel  out  SLAVE_NUM  one-hot slave select
- penable  out  1  APB access phase
- pstrb  out  4  APB4 byte strobes
- pprot  out  3  APB4 protection
- prdata  in  DATA_WIDTH  slave read data
- pready  in  1  slave ready
- pslverr  in  1  slave error

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, rr pointer=0, timeout counter=0.
- IDLE:
  - If any req_valid, grant the first requester at or after the rr pointer, cyclically.
  - Pulse req_ready for that requester for one cycle.
  - Latch its addr/wdata/write/strb/prot and requester id.
  - Advance the rr pointer to grant+1 mod NUM_REQ.
  - Go to SETUP. No request: stay in IDLE, bus outputs 0.
- SETUP (1 cycle):
  - psel[decoded index]=1, penable=0.
  - paddr/pwrite/pwdata/pprot come from the latch.
  - pstrb = latched strobe for writes, forced 4'b0000 for reads.
  - Go to ACCESS.
- ACCESS:
  - penable=1; all address/control/data held stable.
  - pready=1: pulse rsp_valid[id]; rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes. Drop psel/penable next cycle and go to IDLE.
  - pready=0: increment the timeout counter.
  - Timeout: when the counter reaches TIMEOUT-1 with pready still 0, abort. rsp_valid[id]=1, rsp_err=1, rsp_rdata=0, go to IDLE. Counter clears on every entry to SETUP.
- Throughput: minimum 3 cycles per transfer (IDLE accept, SETUP, ACCESS); no back-to-back SETUP without passing through IDLE.
- Requester inputs are ignored after acceptance. A requester whose req_valid drops before grant is simply skipped.
- Simultaneous requests are resolved only by the rr pointer; no fixed priority except out of reset (requester 0 first).
- rsp_valid/rsp_err/rsp_rdata are registered and held for one cycle only, then return to 0.
- Reset asserted mid-transfer: psel/penable drop immediately and no rsp_valid is issued.

Test Plan:
- Single read: req0 reads 0x0000_3004, slave 3 pready=1 in the first ACCESS cycle with prdata=0xDEADBEEF -> psel=8'h08. Cycle trace: req_ready0 @T0, SETUP @T1, ACCESS @T2; rsp_valid=2'b01 and rdata=0xDEADBEEF @T3.
- Write with 2 wait states: req1 writes 0x0000_1000, data 0x1234, strb 4'b0011 -> pstrb=4'b0011, penable held 3 cycles, paddr/pwdata stable throughout, rsp_valid=2'b10, rsp_err=0.
- Contention: req0 and req1 valid continuously for 4 transfers -> grants in order 0,1,0,1; each req_ready pulse is 3 cycles apart.
- Slave error: read with pslverr=1 on the pready cycle -> rsp_err=1, rsp_rdata=prdata; next transfer unaffected.
- Timeout: pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rdata=0; psel=0 on the following cycle.
- Reset during ACCESS: preset_n low -> psel, penable and rsp_valid are 0 immediately; after release, req0 is granted first.
